// File: rtl/axi_w_upsize_packer.sv
// ---------------------------------------------------------------------------
// axi_w_upsize_packer
//   Packs narrow AXI W beats into wide W beats on the wide side of a
//   narrow-to-wide data-width path. One burst command (addr/size/len/burst)
//   is taken from the AW path, then exactly len+1 narrow beats are consumed.
//   Each beat is placed in its wide slot by address; strobes OR-merge and
//   data bytes are written only where the (size-masked) strobe is set.
//   A wide beat is emitted on the last beat, on every FIXED beat, or when the
//   next address leaves the current wide word.
//
// Optional feature (macro AXI_W_PACKER_LEN_CHECK_EN):
//   defined   - slv_w_last_i is compared against the length-derived last on
//               every narrow handshake; a mismatch sets sticky err_o.
//   undefined - slv_w_last_i is ignored and err_o is tied low.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_*                 burst command (valid/ready, addr, size, len, burst)
//   slv_w_*               narrow W channel in (data/strb/user/last/valid/ready)
//   mst_w_*               registered wide W channel out
//   err_o                 sticky length-mismatch flag
// ---------------------------------------------------------------------------

// Per-slot byte merge of one narrow word into its wide slot.
module axi_w_upsize_packer_lane #(
  parameter int unsigned SlvBytes = 4
) (
  input  logic                  sel,
  input  logic [SlvBytes*8-1:0] buf_data,
  input  logic [SlvBytes-1:0]   buf_strb,
  input  logic [SlvBytes*8-1:0] beat_data,
  input  logic [SlvBytes-1:0]   beat_strb,
  output logic [SlvBytes*8-1:0] merged_data,
  output logic [SlvBytes-1:0]   merged_strb
);
  always_comb begin
    merged_data = buf_data;
    merged_strb = buf_strb;
    for (int b = 0; b < int'(SlvBytes); b++) begin
      if (sel && beat_strb[b]) begin
        merged_data[b*8 +: 8] = beat_data[b*8 +: 8];
        merged_strb[b]        = 1'b1;
      end
    end
  end
endmodule

module axi_w_upsize_packer #(
  parameter int unsigned SlvDataWidth = 32,
  parameter int unsigned MstDataWidth = 256,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned UserWidth    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [AddrWidth-1:0]      cmd_addr_i,
  input  logic [2:0]                cmd_size_i,
  input  logic [7:0]                cmd_len_i,
  input  logic [1:0]                cmd_burst_i,
  input  logic [SlvDataWidth-1:0]   slv_w_data_i,
  input  logic [SlvDataWidth/8-1:0] slv_w_strb_i,
  input  logic [UserWidth-1:0]      slv_w_user_i,
  input  logic                      slv_w_last_i,
  input  logic                      slv_w_valid_i,
  output logic                      slv_w_ready_o,
  output logic [MstDataWidth-1:0]   mst_w_data_o,
  output logic [MstDataWidth/8-1:0] mst_w_strb_o,
  output logic [UserWidth-1:0]      mst_w_user_o,
  output logic                      mst_w_last_o,
  output logic                      mst_w_valid_o,
  input  logic                      mst_w_ready_i,
  output logic                      err_o
);
  localparam int unsigned SlvBytes = SlvDataWidth / 8;
  localparam int unsigned MstBytes = MstDataWidth / 8;
  localparam int unsigned NumSlots = MstBytes / SlvBytes;
  localparam int unsigned SlvOff   = $clog2(SlvBytes);
  localparam int unsigned MstOff   = $clog2(MstBytes);
  localparam logic [2:0]  MaxSize  = 3'(SlvOff);
  localparam logic [1:0]  BurstFixed = 2'b00;
  localparam logic [1:0]  BurstWrap  = 2'b10;

  typedef enum logic {IDLE, PACK} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [2:0]           size;   // already clamped to the narrow width
    logic [7:0]           len;
    logic [1:0]           burst;
  } cmd_t;

  state_e                  state_q;
  cmd_t                    cmd_q;
  logic [7:0]              cnt_q;
  logic [MstDataWidth-1:0] buf_data_q;
  logic [MstBytes-1:0]     buf_strb_q;
  logic [MstDataWidth-1:0] out_data_q;
  logic [MstBytes-1:0]     out_strb_q;
  logic [UserWidth-1:0]    out_user_q;
  logic                    out_last_q;
  logic                    out_valid_q;
  logic                    err_q;

  // Address arithmetic for the current beat.
  logic [AddrWidth-1:0] size_bytes, aligned, incr_addr, wrap_mask, next_addr;
  logic [AddrWidth-1:0] lane, slot;
  logic                 last_beat, emit, out_busy, slv_hs;
  logic [SlvBytes-1:0]  beat_strb;
  logic [2:0]           eff_size;
  logic [MstDataWidth-1:0] merged_data;
  logic [MstBytes-1:0]     merged_strb;

  assign eff_size   = (cmd_size_i > MaxSize) ? MaxSize : cmd_size_i;
  assign size_bytes = AddrWidth'(1) << cmd_q.size;
  assign aligned    = cmd_q.addr & ~(size_bytes - AddrWidth'(1));
  assign incr_addr  = aligned + size_bytes;
  // WRAP boundary is (len+1) * 2^size bytes, a power of two for legal bursts.
  assign wrap_mask  = ((AddrWidth'(cmd_q.len) + AddrWidth'(1)) << cmd_q.size) - AddrWidth'(1);

  always_comb begin
    case (cmd_q.burst)
      BurstFixed: next_addr = cmd_q.addr;
      BurstWrap:  next_addr = (cmd_q.addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = incr_addr;
    endcase
  end

  assign last_beat = (cnt_q == cmd_q.len);
  assign emit = last_beat || (cmd_q.burst == BurstFixed) ||
                (next_addr[AddrWidth-1:MstOff] != cmd_q.addr[AddrWidth-1:MstOff]);

  assign lane = aligned & AddrWidth'(SlvBytes - 1);
  assign slot = (aligned & AddrWidth'(MstBytes - 1)) >> SlvOff;

  // Only the 2^size bytes of the beat, starting at the aligned lane, count.
  always_comb begin
    beat_strb = '0;
    for (int b = 0; b < int'(SlvBytes); b++) begin
      beat_strb[b] = slv_w_strb_i[b] && (AddrWidth'(b) >= lane) &&
                     (AddrWidth'(b) < lane + size_bytes);
    end
  end

  for (genvar i = 0; i < int'(NumSlots); i++) begin : g_slot
    axi_w_upsize_packer_lane #(.SlvBytes(SlvBytes)) u_lane (
      .sel         (slot == AddrWidth'(i)),
      .buf_data    (buf_data_q[i*SlvDataWidth +: SlvDataWidth]),
      .buf_strb    (buf_strb_q[i*SlvBytes +: SlvBytes]),
      .beat_data   (slv_w_data_i),
      .beat_strb   (beat_strb),
      .merged_data (merged_data[i*SlvDataWidth +: SlvDataWidth]),
      .merged_strb (merged_strb[i*SlvBytes +: SlvBytes])
    );
  end

  // A beat that emits can only be taken if the output register is free or
  // draining this cycle; non-emitting beats are never stalled.
  assign out_busy      = out_valid_q && !mst_w_ready_i;
  assign slv_w_ready_o = (state_q == PACK) && !(emit && out_busy);
  assign slv_hs        = slv_w_valid_i && slv_w_ready_o;
  assign cmd_ready_o   = (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      buf_data_q  <= '0;
      buf_strb_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && mst_w_ready_i) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_q   <= '{addr: cmd_addr_i, size: eff_size, len: cmd_len_i, burst: cmd_burst_i};
            cnt_q   <= '0;
            state_q <= PACK;
          end
        end
        PACK: begin
          if (slv_hs) begin
            cmd_q.addr <= next_addr;
            cnt_q      <= cnt_q + 8'd1;
            if (emit) begin
              out_data_q  <= merged_data;
              out_strb_q  <= merged_strb;
              out_user_q  <= slv_w_user_i;
              out_last_q  <= last_beat;
              out_valid_q <= 1'b1;
              buf_data_q  <= '0;
              buf_strb_q  <= '0;
            end else begin
              buf_data_q  <= merged_data;
              buf_strb_q  <= merged_strb;
            end
            if (last_beat) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXI_W_PACKER_LEN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      err_q <= 1'b0;
    else if (slv_hs && (slv_w_last_i != last_beat)) err_q <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = slv_w_last_i;
  assign err_q       = 1'b0;
`endif

  assign mst_w_data_o  = out_data_q;
  assign mst_w_strb_o  = out_strb_q;
  assign mst_w_user_o  = out_user_q;
  assign mst_w_last_o  = out_last_q;
  assign mst_w_valid_o = out_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_axi_w_upsize_packer.sv
module tb_axi_w_upsize_packer;
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [63:0]  cmd_addr_i = '0;
  logic [2:0]   cmd_size_i = '0;
  logic [7:0]   cmd_len_i = '0;
  logic [1:0]   cmd_burst_i = '0;
  logic [31:0]  slv_w_data_i = '0;
  logic [3:0]   slv_w_strb_i = '0;
  logic [7:0]   slv_w_user_i = '0;
  logic         slv_w_last_i = 1'b0;
  logic         slv_w_valid_i = 1'b0;
  logic         slv_w_ready_o;
  logic [255:0] mst_w_data_o;
  logic [31:0]  mst_w_strb_o;
  logic [7:0]   mst_w_user_o;
  logic         mst_w_last_o;
  logic         mst_w_valid_o;
  logic         mst_w_ready_i = 1'b1;
  logic         err_o;

  axi_w_upsize_packer #(.SlvDataWidth(32), .MstDataWidth(256), .AddrWidth(64), .UserWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_size_i(cmd_size_i), .cmd_len_i(cmd_len_i), .cmd_burst_i(cmd_burst_i),
    .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i), .slv_w_user_i(slv_w_user_i),
    .slv_w_last_i(slv_w_last_i), .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
    .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o), .mst_w_user_o(mst_w_user_o),
    .mst_w_last_o(mst_w_last_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [255:0] d; logic [31:0] s; logic [7:0] u; logic l; } wb_t;

  int          n_chk = 0;
  int          n_fail = 0;
  wb_t         exp_q[$];
  wb_t         got_q[$];
  logic [31:0] dq[$];
  logic [255:0] m_data = '0;
  logic [31:0]  m_strb = '0;
  bit          full_strb = 1'b1;
  bit          exp_err = 1'b0;
  int          gap_max = 0;
  int          rmode = 0;     // 0: ready high, 1: random, 2: ready low

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       mst_w_ready_i = 1'b1;
      1:       mst_w_ready_i = ($urandom_range(0, 3) != 0);
      default: mst_w_ready_i = 1'b0;
    endcase
  end

  // Output monitor: collects wide handshakes, checks payload stability under stall.
  wb_t prev;
  bit  pend = 1'b0;
  always @(negedge clk) begin
    if (rst_i) pend = 1'b0;
    else begin
      if (pend) begin
        check("stall_valid", mst_w_valid_o, 1);
        check("stall_data", mst_w_data_o, prev.d);
        check("stall_strb", mst_w_strb_o, prev.s);
        check("stall_last", mst_w_last_o, prev.l);
      end
      if (mst_w_valid_o && mst_w_ready_i)
        got_q.push_back('{mst_w_data_o, mst_w_strb_o, mst_w_user_o, mst_w_last_o});
      pend = mst_w_valid_o && !mst_w_ready_i;
      prev = '{mst_w_data_o, mst_w_strb_o, mst_w_user_o, mst_w_last_o};
    end
  end

  // Address of beat k from the AXI burst rules.
  function automatic longint unsigned baddr(input longint unsigned a, input int esz,
                                            input int ln, input int bt, input int k);
    longint unsigned sz, al, wb, lo;
    sz = 64'd1 << esz;
    al = a / sz * sz;
    if (k == 0 || bt == 0) return a;
    if (bt == 2) begin
      wb = longint'(ln + 1) * sz;
      lo = a / wb * wb;
      return lo + (al + longint'(k) * sz) % wb;
    end
    return al + longint'(k) * sz;
  endfunction

  task automatic model_beat(input longint unsigned ak, input longint unsigned nk, input bit lastk,
                            input bit fixed, input int esz, input logic [31:0] d,
                            input logic [3:0] s, input logic [7:0] u, output bit emit);
    longint unsigned al, j;
    int sz, ln, w;
    sz = 1 << esz;
    al = ak / longint'(sz) * longint'(sz);
    for (int o = 0; o < sz; o++) begin
      j  = al + longint'(o);
      ln = int'(j % 4);
      w  = int'(j % 32);
      if (s[ln]) begin
        m_data[w*8 +: 8] = d[ln*8 +: 8];
        m_strb[w] = 1'b1;
      end
    end
    emit = lastk || fixed || (nk / 32 != ak / 32);
    if (emit) begin
      exp_q.push_back('{m_data, m_strb, u, lastk});
      m_data = '0;
      m_strb = '0;
    end
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] ln,
                          input logic [1:0] bt);
    int n = 0;
    bit ok = 1'b0;
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_size_i = sz; cmd_len_i = ln; cmd_burst_i = bt;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = cmd_ready_o;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid_i = 1'b0;
    check("cmd_hs", ok, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic [7:0] u,
                           input bit lst, input bit emit);
    int n = 0;
    bit ok = 1'b0;
    int gap = $urandom_range(0, gap_max);
    repeat (gap) begin @(posedge clk); #1; end
    slv_w_valid_i = 1'b1; slv_w_data_i = d; slv_w_strb_i = s; slv_w_user_i = u; slv_w_last_i = lst;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = slv_w_ready_o;
      check("slv_ready", ok, !(emit && mst_w_valid_o && !mst_w_ready_i));
      @(posedge clk); #1;
      n++;
    end
    slv_w_valid_i = 1'b0;
    check("beat_hs", ok, 1);
    if (emit) check("emit_valid", mst_w_valid_o, 1);
  endtask

  task automatic run_burst(input logic [63:0] a, input logic [2:0] sz, input int ln,
                           input int bt, input int early);
    int esz = (sz > 2) ? 2 : int'(sz);
    longint unsigned ak, nk;
    logic [31:0] d;
    logic [3:0]  s;
    logic [7:0]  u;
    bit lastk, lst, emit;
    send_cmd(a, sz, 8'(ln), 2'(bt));
    for (int k = 0; k <= ln; k++) begin
      ak = baddr(a, esz, ln, bt, k);
      nk = baddr(a, esz, ln, bt, k + 1);
      d = (dq.size() != 0) ? dq.pop_front() : $urandom;
      s = full_strb ? 4'hF : 4'($urandom);
      u = 8'($urandom);
      lastk = (k == ln);
      lst = (early >= 0) ? (k == early) : lastk;
`ifdef AXI_W_PACKER_LEN_CHECK_EN
      if (lst != lastk) exp_err = 1'b1;
`endif
      model_beat(ak, nk, lastk, bt == 0, esz, d, s, u, emit);
      send_beat(d, s, u, lst, emit);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      wb_t g = got_q.pop_front();
      wb_t e = exp_q.pop_front();
      check({tag, "_data"}, g.d, e.d);
      check({tag, "_strb"}, g.s, e.s);
      check({tag, "_user"}, g.u, e.u);
      check({tag, "_last"}, g.l, e.l);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic scen_ramp(input string tag);
    for (int k = 1; k <= 8; k++) dq.push_back(32'(k) * 32'h11111111);
    run_burst(64'h0, 3'd2, 7, 1, -1);
    wait_drain();
    check({tag, "_n"}, got_q.size(), 1);
    check({tag, "_d"}, got_q[0].d,
          256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
    check({tag, "_s"}, got_q[0].s, 32'hFFFFFFFF);
    check({tag, "_l"}, got_q[0].l, 1);
    compare_all(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", mst_w_valid_o, 0);
    check("rst_last", mst_w_last_o, 0);
    check("rst_err", err_o, 0);
    check("rst_slv_ready", slv_w_ready_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Aligned INCR filling a whole wide word.
    scen_ramp("incr8");

    // INCR crossing a wide-word boundary.
    run_burst(64'h18, 3'd2, 3, 1, -1);
    wait_drain();
    check("cross_n", got_q.size(), 2);
    check("cross_s0", got_q[0].s, 32'hFF000000);
    check("cross_l0", got_q[0].l, 0);
    check("cross_s1", got_q[1].s, 32'h000000FF);
    check("cross_l1", got_q[1].l, 1);
    compare_all("cross");

    // FIXED: one wide beat per narrow beat.
    run_burst(64'h4, 3'd2, 2, 0, -1);
    wait_drain();
    check("fixed_n", got_q.size(), 3);
    check("fixed_s0", got_q[0].s, 32'h000000F0);
    check("fixed_s2", got_q[2].s, 32'h000000F0);
    check("fixed_l0", got_q[0].l, 0);
    check("fixed_l1", got_q[1].l, 0);
    check("fixed_l2", got_q[2].l, 1);
    compare_all("fixed");

    // Byte-sized beats straddling a narrow-word boundary.
    dq.push_back(32'hAA000000);
    dq.push_back(32'h000000BB);
    run_burst(64'h3, 3'd0, 1, 1, -1);
    wait_drain();
    check("byte_n", got_q.size(), 1);
    check("byte_s", got_q[0].s, 32'h00000018);
    check("byte_d", got_q[0].d, 256'h000000BB_AA000000);
    check("byte_l", got_q[0].l, 1);
    compare_all("byte");

    // Back-to-back INCR bursts with a downstream stall mid-stream.
    fork
      begin
        run_burst(64'h0, 3'd2, 15, 1, -1);
        run_burst(64'h40, 3'd2, 15, 1, -1);
      end
      begin
        repeat (6) @(posedge clk);
        rmode = 2;
        repeat (10) @(posedge clk);
        rmode = 0;
      end
    join
    wait_drain();
    check("b2b_n", got_q.size(), 4);
    compare_all("b2b");

    // Reset mid-burst, then a fresh burst.
    send_cmd(64'h0, 3'd2, 8'd7, 2'd1);
    send_beat(32'hDEAD0001, 4'hF, 8'h01, 1'b0, 1'b0);
    send_beat(32'hDEAD0002, 4'h3, 8'h02, 1'b0, 1'b0);
    send_beat(32'hDEAD0003, 4'hC, 8'h03, 1'b0, 1'b0);
    rst_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_rst_valid", mst_w_valid_o, 0);
      check("mid_rst_slv_ready", slv_w_ready_o, 0);
    end
    rst_i = 1'b0;
    exp_err = 1'b0;
    check("post_rst_cmd_ready", cmd_ready_o, 1);
    check("post_rst_err", err_o, 0);
    scen_ramp("after_rst");

    // Early narrow last on beat 5 of a len-7 burst.
    run_burst(64'h100, 3'd2, 7, 1, 5);
    wait_drain();
    compare_all("early_last");
    check("err_early", err_o, exp_err);
    run_burst(64'h200, 3'd2, 7, 1, -1);
    wait_drain();
    compare_all("after_early");
    check("err_sticky", err_o, exp_err);

    // Randomized bursts with random downstream back-pressure.
    rmode = 1;
    gap_max = 2;
    full_strb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int bt = $urandom_range(0, 2);
      int ln = (bt == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
      run_burst(64'($urandom), 3'($urandom_range(0, 3)), ln, bt, -1);
    end
    rmode = 0;
    wait_drain();
    compare_all("rand");
    check("err_rand", err_o, exp_err);

    // Reset clears the sticky flag.
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("err_cleared", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
